// File: rtl/dp_ctrl_unit_if.sv
// dp_ctrl_unit_if: instruction, run and datapath-control bundle
// between the core datapath (master) and dp_ctrl_unit (slave).
interface dp_ctrl_unit_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic [31:0]      inst;
   logic             cond_ok;
   logic             Write_PC;
   logic             Write_IR;
   logic             LA;
   logic             LB;
   logic             LC;
   logic             LF;
   logic             S;
   logic             Write_Reg;
   logic             rm_imm_s;
   logic [1:0]       rs_imm_s;
   logic [3:0]       ALU_OP;
   logic [2:0]       SHIFT_OP;
   logic             busy;
   logic             inst_done;
   logic             und_trap;
   logic [CNT_W-1:0] retired_cnt;
   logic [CNT_W-1:0] skip_cnt;
   logic [CNT_W-1:0] und_cnt;
   logic [2:0]       state;

   modport master (
      output run, inst, cond_ok,
      input  Write_PC, Write_IR, LA, LB, LC, LF, S,
      input  Write_Reg, rm_imm_s, rs_imm_s,
      input  ALU_OP, SHIFT_OP, busy, inst_done, und_trap,
      input  retired_cnt, skip_cnt, und_cnt, state
   );

   modport slave (
      input  run, inst, cond_ok,
      output Write_PC, Write_IR, LA, LB, LC, LF, S,
      output Write_Reg, rm_imm_s, rs_imm_s,
      output ALU_OP, SHIFT_OP, busy, inst_done, und_trap,
      output retired_cnt, skip_cnt, und_cnt, state
   );
endinterface

// File: rtl/dp_ctrl_unit.sv
// dp_ctrl_unit: multi-cycle sequencer for the data-processing core.
// Decodes the IR, drives datapath strobes, traps and event counters.
module dp_ctrl_unit #(
   parameter int CNT_W       = 16,
   parameter bit CMP_FORCE_S = 1'b1
) (
   input logic           clk,
   input logic           Rst,
   dp_ctrl_unit_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t     cur;
   state_t     nxt;
   state_t     after;
   logic [3:0] op;
   logic       dp0;
   logic       dp1;
   logic       dp2;
   logic       is_cmp;
   logic       und;
   logic       ev_ret;
   logic       ev_skip;
   logic       ev_und;
   logic [3:0] alu;
   logic [1:0] rs_code;
   logic       s_exec;
   logic       unused_bits;

   assign op     = bus.inst[24:21];
   assign dp0    = bus.inst[27:25] == 3'b000 && !bus.inst[4];
   assign dp1    = bus.inst[27:25] == 3'b000 && bus.inst[4]
                   && !bus.inst[7];
   assign dp2    = bus.inst[27:25] == 3'b001;
   assign is_cmp = op[3:2] == 2'b10;
   // compares never write back, so rd=15 only matters otherwise
   assign und    = !(dp0 || dp1 || dp2)
                   || (!is_cmp && bus.inst[15:12] == 4'hF);

   assign rs_code = dp2 ? 2'b10 : (dp1 ? 2'b01 : 2'b00);
   assign s_exec  = bus.inst[20] || (is_cmp && CMP_FORCE_S);
   assign after   = bus.run ? FETCH : IDLE;

   always_comb begin
      alu = 4'b0000;
      unique case (1'b1)
         op <  4'b1011: alu = {1'b0, op[2:0]};
         op == 4'b1011: alu = 4'b0100;
         op == 4'b1100: alu = 4'b1000;
         default:       alu = {2'b10, op[1:0]};
      endcase
   end

   assign bus.ALU_OP   = alu;
   assign bus.SHIFT_OP = dp2 ? 3'b111 : {bus.inst[6:5], dp1};
   assign bus.state    = cur;
   assign bus.busy     = cur != IDLE;

   assign unused_bits = ^{bus.inst[31:28], bus.inst[19:16],
                          bus.inst[11:8], bus.inst[3:0]};

   always_comb begin
      nxt     = cur;
      ev_ret  = 1'b0;
      ev_skip = 1'b0;
      ev_und  = 1'b0;
      unique case (cur)
         IDLE:   nxt = after;
         FETCH: begin
            if (und) begin
               ev_und = 1'b1;
               nxt    = after;
            end else if (!bus.cond_ok) begin
               ev_skip = 1'b1;
               nxt     = after;
            end else begin
               nxt = DECODE;
            end
         end
         DECODE: nxt = EXEC;
         EXEC: begin
            if (is_cmp) begin
               ev_ret = 1'b1;
               nxt    = after;
            end else begin
               nxt = WB;
            end
         end
         WB: begin
            ev_ret = 1'b1;
            nxt    = after;
         end
         default: nxt = IDLE;
      endcase
   end

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // strobes follow the next state so each spans its whole state cycle
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         cur             <= IDLE;
         bus.Write_PC    <= 1'b0;
         bus.Write_IR    <= 1'b0;
         bus.LA          <= 1'b0;
         bus.LB          <= 1'b0;
         bus.LC          <= 1'b0;
         bus.LF          <= 1'b0;
         bus.S           <= 1'b0;
         bus.Write_Reg   <= 1'b0;
         bus.rm_imm_s    <= 1'b0;
         bus.rs_imm_s    <= 2'b00;
         bus.inst_done   <= 1'b0;
         bus.und_trap    <= 1'b0;
         bus.retired_cnt <= '0;
         bus.skip_cnt    <= '0;
         bus.und_cnt     <= '0;
      end else begin
         cur           <= nxt;
         bus.Write_PC  <= nxt == FETCH;
         bus.Write_IR  <= nxt == FETCH;
         bus.LA        <= nxt == DECODE;
         bus.LB        <= nxt == DECODE;
         bus.LC        <= nxt == DECODE;
         bus.LF        <= nxt == EXEC;
         bus.S         <= nxt == EXEC && s_exec;
         bus.Write_Reg <= nxt == WB;
         if (nxt == EXEC) begin
            bus.rm_imm_s <= dp2;
            bus.rs_imm_s <= rs_code;
         end
         bus.inst_done <= ev_ret;
         bus.und_trap  <= ev_und;
         if (ev_ret)
            bus.retired_cnt <= sat_inc(bus.retired_cnt);
         if (ev_skip)
            bus.skip_cnt <= sat_inc(bus.skip_cnt);
         if (ev_und)
            bus.und_cnt <= sat_inc(bus.und_cnt);
      end
   end

endmodule

// File: tb/tb_dp_ctrl_unit.sv
// tb_dp_ctrl_unit: scoreboard bench for dp_ctrl_unit, two instances
// (16-bit counters / forced compare S, and 2-bit counters / no force).
module tb_dp_ctrl_unit;

   localparam int P_IDLE = 0;
   localparam int P_F    = 1;
   localparam int P_D    = 2;
   localparam int P_E    = 3;
   localparam int P_W    = 4;

   logic        clk = 1'b0;
   logic        Rst;
   logic        run;
   logic        cond_ok;
   logic [31:0] inst;

   always #5 clk = ~clk;

   dp_ctrl_unit_if #(.CNT_W(16)) b1();
   dp_ctrl_unit_if #(.CNT_W(2))  b2();

   assign b1.run     = run;
   assign b1.inst    = inst;
   assign b1.cond_ok = cond_ok;
   assign b2.run     = run;
   assign b2.inst    = inst;
   assign b2.cond_ok = cond_ok;

   dp_ctrl_unit #(.CNT_W(16), .CMP_FORCE_S(1'b1)) u1 (
      .clk(clk), .Rst(Rst), .bus(b1.slave)
   );
   dp_ctrl_unit #(.CNT_W(2), .CMP_FORCE_S(1'b0)) u2 (
      .clk(clk), .Rst(Rst), .bus(b2.slave)
   );

   logic [71:0] q1[$];
   logic [29:0] q2[$];
   int          passed = 0;
   int          total  = 0;
   bit          mon_en = 1'b0;

   // reference model state
   logic [31:0] m_inst;
   logic        m_rm;
   logic [1:0]  m_rs;
   int          c_ret;
   int          c_skp;
   int          c_und;
   bit          p_done;
   bit          p_trap;

   // 0=DP0 1=DP1 2=DP2 3=UND (format only)
   function automatic int fmt(input logic [31:0] i);
      if (i[27:25] == 3'b001) return 2;
      if (i[27:25] != 3'b000) return 3;
      if (!i[4]) return 0;
      if (!i[7]) return 1;
      return 3;
   endfunction

   function automatic logic [3:0] alu_of(input logic [3:0] o);
      if (o < 4'd11) return {1'b0, o[2:0]};
      if (o == 4'd11) return 4'd4;
      if (o == 4'd12) return 4'd8;
      return {2'b10, o[1:0]};
   endfunction

   function automatic int sat(input int c, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   task automatic chk(input string name, input logic [71:0] act,
                      input logic [71:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic model_reset();
      q1.delete();
      q2.delete();
      m_rm   = 1'b0;
      m_rs   = 2'b00;
      c_ret  = 0;
      c_skp  = 0;
      c_und  = 0;
      p_done = 1'b0;
      p_trap = 1'b0;
   endtask

   task automatic emit(input int ph);
      logic [7:0]  sb1;
      logic [7:0]  sb2;
      logic [2:0]  sh;
      logic [3:0]  al;
      int          f;
      bit          cmp;
      f   = fmt(m_inst);
      cmp = m_inst[24:23] == 2'b10;
      sb1 = 8'h00;
      sb2 = 8'h00;
      case (ph)
         P_F: begin sb1 = 8'b1100_0000; sb2 = sb1; end
         P_D: begin sb1 = 8'b0011_1000; sb2 = sb1; end
         P_E: begin
            sb1  = {5'b0, 1'b1, m_inst[20] | cmp, 1'b0};
            sb2  = {5'b0, 1'b1, m_inst[20], 1'b0};
            m_rm = f == 2;
            m_rs = 2'(f);
         end
         P_W: begin sb1 = 8'b0000_0001; sb2 = sb1; end
         default: ;
      endcase
      al = alu_of(m_inst[24:21]);
      sh = (f == 2) ? 3'b111 : {m_inst[6:5], f == 1};
      q1.push_back({3'(ph), sb1, m_rm, m_rs, al, sh, ph != P_IDLE,
                    p_done, p_trap, 16'(sat(c_ret, 16)),
                    16'(sat(c_skp, 16)), 16'(sat(c_und, 16))});
      q2.push_back({3'(ph), sb2, m_rm, m_rs, al, sh, ph != P_IDLE,
                    p_done, p_trap, 2'(sat(c_ret, 2)),
                    2'(sat(c_skp, 2)), 2'(sat(c_und, 2))});
      p_done = 1'b0;
      p_trap = 1'b0;
   endtask

   task automatic cyc(input int ph);
      emit(ph);
      @(posedge clk);
      #1;
   endtask

   task automatic do_inst(input logic [31:0] i, input logic ok,
                          input bit drop);
      int f;
      bit cmp;
      bit u;
      f       = fmt(i);
      cmp     = i[24:23] == 2'b10;
      u       = (f == 3) || (!cmp && i[15:12] == 4'hF);
      inst    = i;
      cond_ok = ok;
      m_inst  = i;
      if (u || !ok) begin
         if (drop) run = 1'b0;
         cyc(P_F);
         if (u) begin c_und++; p_trap = 1'b1; end
         else c_skp++;
      end else begin
         cyc(P_F);
         cyc(P_D);
         if (drop) run = 1'b0;
         cyc(P_E);
         if (!cmp) cyc(P_W);
         c_ret++;
         p_done = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (q1.size() == 0 || q2.size() == 0) begin
            total++;
            $display("FAIL underflow: got output with no expected entry");
         end else begin
            chk("u1_cycle",
                {b1.state, b1.Write_PC, b1.Write_IR, b1.LA, b1.LB,
                 b1.LC, b1.LF, b1.S, b1.Write_Reg, b1.rm_imm_s,
                 b1.rs_imm_s, b1.ALU_OP, b1.SHIFT_OP, b1.busy,
                 b1.inst_done, b1.und_trap, b1.retired_cnt,
                 b1.skip_cnt, b1.und_cnt},
                72'(q1.pop_front()));
            chk("u2_cycle",
                72'({b2.state, b2.Write_PC, b2.Write_IR, b2.LA, b2.LB,
                     b2.LC, b2.LF, b2.S, b2.Write_Reg, b2.rm_imm_s,
                     b2.rs_imm_s, b2.ALU_OP, b2.SHIFT_OP, b2.busy,
                     b2.inst_done, b2.und_trap, b2.retired_cnt,
                     b2.skip_cnt, b2.und_cnt}),
                72'(q2.pop_front()));
         end
      end
   end

   initial begin
      logic [31:0] r;
      logic        ok;
      bit          drop;
      int          k;
      Rst     = 1'b1;
      run     = 1'b0;
      inst    = 32'h0;
      cond_ok = 1'b0;
      m_inst  = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      Rst    = 1'b0;
      mon_en = 1'b1;
      run    = 1'b1;
      cyc(P_IDLE);

      do_inst(32'hE0821003, 1'b1, 1'b0);
      do_inst(32'hE2921005, 1'b1, 1'b0);
      do_inst(32'hE1520003, 1'b1, 1'b0);
      do_inst(32'hE1420003, 1'b1, 1'b0);
      repeat (3) do_inst(32'h00821003, 1'b0, 1'b0);
      do_inst(32'hE082F003, 1'b0, 1'b0);
      do_inst(32'hE0821003, 1'b1, 1'b1);
      cyc(P_IDLE);
      cyc(P_IDLE);
      run = 1'b1;
      cyc(P_IDLE);

      for (int n = 0; n < 300; n++) begin
         r = $urandom;
         k = $urandom_range(0, 9);
         if (k <= 3) begin
            r[27:25] = 3'b000; r[4] = 1'b0;
         end else if (k <= 5) begin
            r[27:25] = 3'b000; r[4] = 1'b1; r[7] = 1'b0;
         end else if (k <= 7) begin
            r[27:25] = 3'b001;
         end else if (k == 8) begin
            r[27:25] = 3'b000; r[4] = 1'b0;
            r[24:23] = 2'b10; r[15:12] = 4'hF;
         end
         if ($urandom_range(0, 7) == 0) r[15:12] = 4'hF;
         ok   = $urandom_range(0, 3) != 0;
         drop = $urandom_range(0, 15) == 0;
         do_inst(r, ok, drop);
         if (drop) begin
            repeat ($urandom_range(0, 2)) cyc(P_IDLE);
            run = 1'b1;
            cyc(P_IDLE);
         end
      end

      // asynchronous reset in the middle of EXEC
      run     = 1'b1;
      inst    = 32'hE0821003;
      cond_ok = 1'b1;
      m_inst  = inst;
      cyc(P_F);
      cyc(P_D);
      mon_en = 1'b0;
      #2;
      Rst = 1'b1;
      #1;
      chk("u1_async_rst",
          72'({b1.state, b1.Write_PC, b1.Write_IR, b1.LA, b1.LB,
               b1.LC, b1.LF, b1.S, b1.Write_Reg, b1.rm_imm_s,
               b1.rs_imm_s, b1.busy, b1.inst_done, b1.und_trap,
               b1.retired_cnt, b1.skip_cnt, b1.und_cnt}),
          72'h0);
      chk("u2_async_rst",
          72'({b2.state, b2.Write_PC, b2.Write_IR, b2.LA, b2.LB,
               b2.LC, b2.LF, b2.S, b2.Write_Reg, b2.rm_imm_s,
               b2.rs_imm_s, b2.busy, b2.inst_done, b2.und_trap,
               b2.retired_cnt, b2.skip_cnt, b2.und_cnt}),
          72'h0);
      @(posedge clk);
      #1;
      Rst = 1'b0;
      model_reset();
      mon_en = 1'b1;
      cyc(P_IDLE);

      for (int n = 0; n < 5; n++)
         do_inst(32'h00821003, 1'b0, n == 4);
      cyc(P_IDLE);
      cyc(P_IDLE);
      chk("skip_sat", 72'({b1.skip_cnt, 14'(0), b2.skip_cnt}),
          72'({16'd5, 14'(0), 2'd3}));

      mon_en = 1'b0;
      chk("queue_drained", 72'(q1.size() + q2.size()), 72'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dp_ctrl_unit.md
Name: dp_ctrl_unit

Overview:
Parametrised multi-cycle control unit for the data-processing core, and the successor to the fixed in-CPU controller. It decodes the 32-bit instruction word and sequences fetch, operand-load, execute and write-back. It drives every datapath strobe plus the ALU and shifter selects. It adds behaviour the previous controller lacks:
- run/halt handshake
- compare ops (TST/TEQ/CMP/CMN) with no write-back and forced flag update
- undefined-instruction trap pulse
- per-instruction done pulse
- saturating retired/skipped/undefined counters

Parameters:
CNT_W, 16, width of each saturating event counter
CMP_FORCE_S, 1, when 1 compare ops (OP 1000-1011) assert S in EXEC regardless of IR[20]

Ports:
clk  in  1  clock
Rst  in  1  reset, asynchronous, active-high
run  in  1  level; 1 = keep executing, 0 = halt to IDLE at the next instruction boundary
inst  in  32  current instruction word from the IR
cond_ok  in  1  condition-code check result for inst[31:28] against the current NZCV
Write_PC, Write_IR  out  1  PC increment and IR load strobes
LA, LB, LC  out  1  operand register load strobes
LF  out  1  result register load strobe
S  out  1  NZCV update strobe
Write_Reg  out  1  register-file write strobe
rm_imm_s  out  1  1 = shifter data is the imm8 field
rs_imm_s  out  2  shift-amount select: 00 imm5, 01 Rs[7:0], 10 rot*2
ALU_OP  out  4  ALU operation
SHIFT_OP  out  3  shifter operation
busy  out  1  1 in any state except IDLE
inst_done  out  1  one-cycle pulse when an instruction retires
und_trap  out  1  one-cycle pulse when an undefined instruction is rejected
retired_cnt, skip_cnt, und_cnt  out  CNT_W each  saturating event counters
state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4

Behaviour:
- Decode (combinational on inst):
  - DP0: [27:25]=000 and [4]=0.
  - DP1: [27:25]=000, [4]=1 and [7]=0.
  - DP2: [27:25]=001.
  - Every other encoding is UND.
  - is_cmp = OP[3:2]==10 where OP=[24:21].
  - rd=[15:12]=1111 on a non-compare is UND. Compares ignore rd.
- ALU_OP from OP:
  - OP<1011 gives {0,OP[2:0]}.
  - 1011 gives 0100.
  - 1100 gives 1000.
  - Otherwise {10,OP[1:0]}.
- SHIFT_OP is 111 for DP2, else {inst[6:5], DP==DP1}. ALU_OP and SHIFT_OP are combinational.
- All strobes, rm_imm_s, rs_imm_s, inst_done and und_trap are registered on posedge from the next state. Each strobe is high for exactly the whole cycle of its state, so the datapath loads on the mid-cycle negedge.
- Transitions:
  - IDLE: go to FETCH if run, else stay.
  - FETCH: the decision uses inst and cond_ok.
    - Valid and cond_ok: go to DECODE.
    - UND: pulse und_trap, increment und_cnt. Next is FETCH if run, else IDLE.
    - Valid but !cond_ok: increment skip_cnt. Next is FETCH if run, else IDLE.
    - UND takes priority over cond fail; a UND instruction never increments skip_cnt.
  - DECODE: go to EXEC.
  - EXEC: compare ops retire here. Otherwise go to WB.
  - WB: retire.
  - Retire: pulse inst_done, increment retired_cnt. Next is FETCH if run, else IDLE.
- Strobes per state:
  - FETCH: Write_PC=Write_IR=1.
  - DECODE: LA=LB=LC=1.
  - EXEC: LF=1.
    - rm_imm_s = (DP==DP2).
    - rs_imm_s = DP code (DP0=00, DP1=01, DP2=10).
    - S = inst[20], or 1 if is_cmp and CMP_FORCE_S.
  - WB: Write_Reg=1.
  - All other strobes are 0. rm_imm_s and rs_imm_s hold their value outside EXEC.
- Latency: normal op 4 cycles FETCH to FETCH; compare 3 cycles; skipped or UND 1 cycle.
- Write_Reg is never asserted for a compare or a UND instruction.
- Counters saturate at all-ones with no wrap. All three may increment in different cycles; at most one event fires per cycle.
- run deasserted mid-instruction: the instruction completes and retires, then the unit enters IDLE.
- Reset (async, any state including mid-EXEC): state=IDLE immediately.
  - Every strobe, rm_imm_s, rs_imm_s, inst_done, und_trap and busy = 0.
  - All counters = 0.
  - No partial write-back after reset release.

Test Plan:
1. run=1, inst=0xE0821003 (ADD R1,R2,R3), cond_ok=1 -> states 1,2,3,4,1. LA/LB/LC high in DECODE; LF high, S=0, rs_imm_s=00, ALU_OP=0100, SHIFT_OP=000 in EXEC; Write_Reg in WB; inst_done pulse; retired_cnt=1.
2. inst=0xE2921005 (ADDS R1,R2,#5) -> in EXEC rm_imm_s=1, rs_imm_s=10, SHIFT_OP=111, S=1; 4-cycle latency.
3. inst=0xE1520003 (CMP R2,R3) -> ALU_OP=0010, S=1 in EXEC, no WB state, Write_Reg never high, 3-cycle latency. Repeat with CMP_FORCE_S=0 and inst[20]=0 -> S=0 in EXEC.
4. inst=0x00821003 with cond_ok=0 -> stays in FETCH, skip_cnt increments every cycle, no LA/LF. inst=0xE082F003 (rd=15) -> und_trap pulse, und_cnt increments, skip_cnt unchanged even with cond_ok=0.
5. Drop run during EXEC of ADD -> WB completes, inst_done pulses, state=IDLE, busy=0. Raise run -> FETCH next cycle.
6. Assert Rst mid-EXEC -> all outputs 0 and state=0 without waiting for a clock edge. With CNT_W=2, 5 skipped instructions -> skip_cnt=3.
